// File: rtl/vcp_uart_pkg.sv
// vcp_uart_pkg: shared frame constants, parser state type and opcode legality check
package vcp_uart_pkg;

    localparam logic [7:0] OP_WRITE = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CMD
    } parser_state_t;

    function automatic logic is_legal_op(input logic [7:0] op, input int num_ops);
        return (op != OP_WRITE) && ({24'd0, op} <= num_ops);
    endfunction

endpackage

// File: rtl/rx_timeout_counter.sv
// rx_timeout_counter: flags TIMEOUT_CYC consecutive idle cycles while running; tied off when TIMEOUT_CYC is 0
module rx_timeout_counter #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYC + 1);
            logic [CW-1:0] cnt;
            always_ff @(posedge clk)
                if (reset || clear) cnt <= '0;
                else if (run) cnt <= cnt + CW'(1);
            // a byte arriving in the would-be expiry cycle clears instead of expiring
            assign expired = run && !clear && (cnt == CW'(TIMEOUT_CYC - 1));
        end
    endgenerate
endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: parses UART byte frames into indexed vector element writes or handshaked commands
module uart_frame_parser
    import vcp_uart_pkg::*;
#(
    parameter int ELEM_BYTES  = 2,
    parameter int VEC_LEN     = 1024,
    parameter int NUM_OPS     = 8,
    parameter int TIMEOUT_CYC = 100000,
    localparam int AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1,
    localparam int DW = 8 * ELEM_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          rx_ready,
    input  logic [7:0]    rx_data,
    output logic          wr_valid,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          cmd_valid,
    output logic [7:0]    cmd_op,
    input  logic          cmd_ready,
    output logic          busy,
    output logic          frame_done,
    output logic          err_opcode,
    output logic          err_timeout,
    output logic          err_overrun
);
    localparam int BW = (ELEM_BYTES > 1) ? $clog2(ELEM_BYTES) : 1;

    parser_state_t state;
    logic [BW-1:0] byte_cnt;
    logic [AW-1:0] elem_idx;
    logic [DW-1:0] asm_reg, elem;
    logic          expired;

    wire last_byte = (byte_cnt == BW'(ELEM_BYTES - 1));
    wire last_elem = (elem_idx == AW'(VEC_LEN - 1));

    rx_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
        .clk(clk),
        .reset(reset),
        .clear(state != PAYLOAD || rx_ready),
        .run(state == PAYLOAD),
        .expired(expired)
    );

    always_comb begin
        elem = asm_reg;
        for (int i = 0; i < ELEM_BYTES; i++)
            elem[8*i +: 8] = (BW'(i) == byte_cnt) ? rx_data : asm_reg[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            elem_idx    <= '0;
            asm_reg     <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cmd_valid   <= 1'b0;
            cmd_op      <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            wr_valid    <= 1'b0;
            frame_done  <= 1'b0;
            err_opcode  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            case (state)
                IDLE: if (rx_ready && enable) begin
                    if (rx_data == OP_WRITE) begin
                        state    <= PAYLOAD;
                        busy     <= 1'b1;
                        byte_cnt <= '0;
                        elem_idx <= '0;
                    end else if (is_legal_op(rx_data, NUM_OPS)) begin
                        state     <= CMD;
                        busy      <= 1'b1;
                        cmd_op    <= rx_data;
                        cmd_valid <= 1'b1;
                    end else begin
                        err_opcode <= 1'b1;
                    end
                end
                PAYLOAD: if (rx_ready) begin
                    asm_reg <= elem;
                    if (last_byte) begin
                        byte_cnt <= '0;
                        elem_idx <= elem_idx + AW'(1);
                        wr_valid <= 1'b1;
                        wr_addr  <= elem_idx;
                        wr_data  <= elem;
                        if (last_elem) begin
                            frame_done <= 1'b1;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end
                    end else begin
                        byte_cnt <= byte_cnt + BW'(1);
                    end
                end else if (expired) begin
                    err_timeout <= 1'b1;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
                CMD: begin
                    err_overrun <= rx_ready;
                    if (cmd_ready) begin
                        cmd_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: scoreboard bench for uart_frame_parser with small frames and a short timeout
module tb_uart_frame_parser;
    localparam int EB = 2, VL = 4, NO = 8, TC = 50;

    logic clk = 0, reset = 1, enable = 0, rx_ready = 0, cmd_ready = 0;
    logic [7:0] rx_data = 0;
    logic wr_valid, cmd_valid, busy, frame_done, err_opcode, err_timeout, err_overrun;
    logic [1:0] wr_addr;
    logic [15:0] wr_data;
    logic [7:0] cmd_op;
    int checks = 0, errors = 0, n_done = 0, n_op = 0, n_tout = 0, n_ovr = 0;

    typedef struct packed {
        logic [1:0]  addr;
        logic [15:0] data;
        logic        done;
    } wr_t;
    wr_t exp_q[$];
    wr_t exp_w;

    always #5 clk = ~clk;

    uart_frame_parser #(.ELEM_BYTES(EB), .VEC_LEN(VL), .NUM_OPS(NO), .TIMEOUT_CYC(TC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx_ready(rx_ready), .rx_data(rx_data),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready), .busy(busy),
        .frame_done(frame_done), .err_opcode(err_opcode), .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    always @(negedge clk) begin
        n_done += int'(frame_done);
        n_op   += int'(err_opcode);
        n_tout += int'(err_timeout);
        n_ovr  += int'(err_overrun);
        if (wr_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%h done=%b, required no write", wr_addr, wr_data, frame_done);
            end else begin
                exp_w = exp_q.pop_front();
                if ({wr_addr, wr_data, frame_done} !== exp_w) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%h done=%b, required addr=%0d data=%h done=%b",
                             wr_addr, wr_data, frame_done, exp_w.addr, exp_w.data, exp_w.done);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_ready = 1; step(); rx_ready = 0;
    endtask

    task automatic send_elem(input logic [1:0] a, input logic [15:0] d, input logic done);
        exp_q.push_back({a, d, done});
        send_byte(d[7:0]); send_byte(d[15:8]);
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if ({wr_valid, wr_addr, wr_data, cmd_valid, cmd_op, busy, frame_done, err_opcode, err_timeout, err_overrun} !== '0) begin
            errors++;
            $display("FAIL %s: got wr_valid=%b addr=%0d data=%h cmd_valid=%b op=%h busy=%b done=%b errs=%b%b%b, required all 0",
                     name, wr_valid, wr_addr, wr_data, cmd_valid, cmd_op, busy, frame_done, err_opcode, err_timeout, err_overrun);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset_state");
        reset = 0; enable = 1;
        step();
    endtask

    task automatic test_write_frame;
        int d0 = n_done;
        send_byte(8'h00);
        check_int("write_busy", int'(busy), 1);
        send_elem(2'd0, 16'h2211, 1'b0);
        send_elem(2'd1, 16'h4433, 1'b0);
        send_elem(2'd2, 16'h6655, 1'b0);
        send_elem(2'd3, 16'h8877, 1'b1);
        step();
        check_int("write_end_busy", int'(busy), 0);
        check_int("write_all_seen", exp_q.size(), 0);
        check_int("write_done_count", n_done, d0 + 1);
    endtask

    task automatic test_command;
        int d0 = n_done, o0 = n_ovr;
        send_byte(8'h05);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_op !== 8'h05 || busy !== 1'b1) begin
                errors++;
                $display("FAIL cmd_hold[%0d]: got valid=%b op=%h busy=%b, required valid=1 op=05 busy=1", i, cmd_valid, cmd_op, busy);
            end
            if (i == 4) send_byte(8'h12);
            else step();
        end
        check_int("cmd_overrun", n_ovr, o0 + 1);
        check_int("cmd_no_early_done", n_done, d0);
        cmd_ready = 1;
        step();
        cmd_ready = 0;
        checks++;
        if (cmd_valid !== 1'b0 || frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cmd_handshake: got valid=%b done=%b busy=%b, required valid=0 done=1 busy=0", cmd_valid, frame_done, busy);
        end
        step();
        check_int("cmd_done_count", n_done, d0 + 1);
    endtask

    task automatic test_opcode;
        int o0 = n_op, d0 = n_done;
        send_byte(8'h09);
        check_int("op09_busy", int'(busy), 0);
        send_byte(8'hFF);
        check_int("opFF_busy", int'(busy), 0);
        step();
        check_int("opcode_errors", n_op, o0 + 2);
        enable = 0;
        send_byte(8'h00);
        check_int("disabled_hdr_busy", int'(busy), 0);
        send_byte(8'h11);
        step();
        check_int("disabled_busy", int'(busy), 0);
        check_int("disabled_no_error", n_op, o0 + 2);
        enable = 1;
        send_byte(8'h08);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h08) begin
            errors++;
            $display("FAIL op_max_legal: got valid=%b op=%h, required valid=1 op=08", cmd_valid, cmd_op);
        end
        cmd_ready = 1; step(); cmd_ready = 0; step();
        check_int("op_max_done", n_done, d0 + 1);
    endtask

    task automatic test_timeout;
        int t0 = n_tout, d0 = n_done;
        send_byte(8'h00);
        send_elem(2'd0, 16'h2211, 1'b0);
        send_byte(8'h33);
        repeat (TC - 1) @(posedge clk);
        #1;
        check_int("timeout_not_early", n_tout, t0);
        check_int("timeout_busy_before", int'(busy), 1);
        step(); step();
        check_int("timeout_pulse", n_tout, t0 + 1);
        check_int("timeout_idle", int'(busy), 0);
        check_int("timeout_no_done", n_done, d0);
        send_byte(8'h03);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 8'h03) begin
            errors++;
            $display("FAIL after_timeout_cmd: got valid=%b op=%h, required valid=1 op=03", cmd_valid, cmd_op);
        end
        cmd_ready = 1; step(); cmd_ready = 0; step();
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'h00);
        send_elem(2'd0, 16'h0201, 1'b0);
        send_elem(2'd1, 16'h0403, 1'b0);
        send_byte(8'h05);
        reset = 1;
        step();
        check_idle_zero("reset_mid_frame");
        reset = 0;
        step();
        send_byte(8'h00);
        send_elem(2'd0, 16'hBEEF, 1'b0);
        send_elem(2'd1, 16'hCAFE, 1'b0);
        send_elem(2'd2, 16'h1234, 1'b0);
        send_elem(2'd3, 16'h5678, 1'b1);
        step();
        check_int("post_reset_all_seen", exp_q.size(), 0);
    endtask

    task automatic test_timeout_race;
        int t0 = n_tout;
        send_byte(8'h00);
        send_byte(8'hA1);
        repeat (TC - 1) @(posedge clk);
        #1;
        exp_q.push_back({2'd0, 16'hB2A1, 1'b0});
        send_byte(8'hB2);
        send_elem(2'd1, 16'hD4C3, 1'b0);
        send_elem(2'd2, 16'hF6E5, 1'b0);
        send_elem(2'd3, 16'h1807, 1'b1);
        step();
        check_int("race_no_timeout", n_tout, t0);
        check_int("race_all_seen", exp_q.size(), 0);
        check_int("race_idle", int'(busy), 0);
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_command();
        test_opcode();
        test_timeout();
        test_reset_mid_frame();
        test_timeout_race();
        repeat (3) step();
        check_int("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
